// File: rtl/regs.sv
// General-purpose register file with two combinational read ports.
// Entries 1..N-1 are cleared by a post-reset sequencer; r0 reads zero.
module regs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read1_enable,
   input  logic [ADDR_WIDTH-1:0] read1_addr,
   output logic [DATA_WIDTH-1:0] read1_data,
   input  logic                  read2_enable,
   input  logic [ADDR_WIDTH-1:0] read2_addr,
   output logic [DATA_WIDTH-1:0] read2_data,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] count;
   logic [ADDR_WIDTH-1:0] count_next;
   logic                  ready_next;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   logic                  wr_live;

   assign wr_live = (state == RUN) && write_enable
                    && (write_addr != '0);

   always_comb begin
      state_next = state;
      count_next = count;
      ready_next = ready;
      mem_we     = 1'b0;
      mem_addr   = count;
      mem_wdata  = '0;
      unique case (state)
         INIT: begin
            // Gate on reset so an edge seen while held in reset never writes.
            mem_we     = reset;
            count_next = count + 1'b1;
            if (&count) begin
               state_next = RUN;
               ready_next = 1'b1;
               count_next = count;
            end
         end
         RUN: begin
            if (wr_live) begin
               mem_we    = reset;
               mem_addr  = write_addr;
               mem_wdata = write_data;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= INIT;
         count <= ADDR_WIDTH'(1);
         ready <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         ready <= ready_next;
      end
   end

   // No reset on the array so it can map onto RAM-style storage.
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   always_comb begin
      read1_data = '0;
      if (!reset || state == INIT || !read1_enable
          || read1_addr == '0) begin
         read1_data = '0;
      end else if (wr_live && write_addr == read1_addr) begin
         read1_data = write_data;
      end else begin
         read1_data = mem[read1_addr];
      end
   end

   always_comb begin
      read2_data = '0;
      if (!reset || state == INIT || !read2_enable
          || read2_addr == '0) begin
         read2_data = '0;
      end else if (wr_live && write_addr == read2_addr) begin
         read2_data = write_data;
      end else begin
         read2_data = mem[read2_addr];
      end
   end

endmodule
